ram_writer: RTL and testbench

RAM_WRITER -- requirements
Module: ram_writer

---
 rtl/ram_writer.sv | 85 ++++++++
 tb/tb_ram_writer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_writer.sv
// ram_writer: size x width RAM with a single-word write port, a whole-array fill engine and a registered read port.
// Optional macro RAM_WR_BYPASS_EN: a read of the address written in the same cycle returns the new data.
module ram_writer #(
  parameter int size  = 2048,
  parameter int width = 16,
  parameter int asize = $clog2(size)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [asize-1:0] wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic             fill_start,
  input  logic [width-1:0] fill_data,
  output logic             busy,
  output logic             fill_done,
  input  logic             rd_en,
  input  logic [asize-1:0] rd_addr,
  output logic [width-1:0] rd_dout
);
  typedef enum logic {IDLE, FILL} state_t;
  localparam logic [asize:0]   SZ   = (asize+1)'(size);
  localparam logic [asize-1:0] LAST = asize'(size-1);
  state_t             state_q;
  logic [asize-1:0]   cnt_q;
  logic [width-1:0]   fval_q;
  logic [width-1:0]   dout_q;
  logic               done_q;
  logic [width-1:0]   mem [size];
  logic               we_d;
  logic [asize-1:0]   waddr_d;
  logic [width-1:0]   wdata_d;
  logic [width-1:0]   mem_rd;
  logic [width-1:0]   rdata_d;
  // Write-port arbitration: the fill engine owns the array while busy; out-of-range single writes are dropped.
  always_comb begin
    wr_ready = (state_q == IDLE) && !fill_start;
    we_d     = (state_q == FILL) || (wr_valid && wr_ready && ({1'b0, wr_addr} < SZ));
    waddr_d  = (state_q == FILL) ? cnt_q : wr_addr;
    wdata_d  = (state_q == FILL) ? fval_q : wr_data;
    mem_rd   = ({1'b0, rd_addr} < SZ) ? mem[rd_addr] : '0;
  end
`ifdef RAM_WR_BYPASS_EN
  assign rdata_d = (we_d && waddr_d == rd_addr) ? wdata_d : mem_rd;
`else
  assign rdata_d = mem_rd;
`endif
  assign busy      = state_q == FILL;
  assign fill_done = done_q;
  assign rd_dout   = dout_q;
  // Storage array: deliberately not reset so an aborted fill leaves written words intact.
  always_ff @(posedge clk) begin
    if (we_d) mem[waddr_d] <= wdata_d;
  end
  // Registered read port with hold when rd_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else if (rd_en) dout_q <= rdata_d;
  end
  // Fill FSM: latch the value, sweep 0..size-1, then pulse fill_done on the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fval_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (fill_start) begin
          fval_q  <= fill_data;
          cnt_q   <= '0;
          state_q <= FILL;
        end
      end else begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + asize'(1);
        if (cnt_q == LAST) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: scoreboard bench for ram_writer (16x8 main instance, 10x8 instance for the non-power-of-2 fill).
module tb_ram_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_wv = 0, a_wr, a_fs = 0, a_busy, a_done, a_re = 0;
  logic [3:0] a_wa = 0, a_ra = 0;
  logic [7:0] a_wd = 0, a_fd = 0, a_rd;
  logic b_wv = 0, b_wr, b_fs = 0, b_busy, b_done, b_re = 0;
  logic [3:0] b_wa = 0, b_ra = 0;
  logic [7:0] b_wd = 0, b_fd = 0, b_rd;
  logic [7:0] qa[$], qb[$];
  logic [7:0] ma [16];
  logic a_rv = 0, b_rv = 0;
  int pass = 0, total = 0;

  ram_writer #(.size(16), .width(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(a_wv), .wr_ready(a_wr), .wr_addr(a_wa), .wr_data(a_wd),
    .fill_start(a_fs), .fill_data(a_fd), .busy(a_busy), .fill_done(a_done),
    .rd_en(a_re), .rd_addr(a_ra), .rd_dout(a_rd));
  ram_writer #(.size(10), .width(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wv), .wr_ready(b_wr), .wr_addr(b_wa), .wr_data(b_wd),
    .fill_start(b_fs), .fill_data(b_fd), .busy(b_busy), .fill_done(b_done),
    .rd_en(b_re), .rd_addr(b_ra), .rd_dout(b_rd));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Read-data monitor: every read accepted at an edge is compared one half-cycle later.
  always @(posedge clk) begin
    a_rv <= a_re;
    b_rv <= b_re;
  end
  always @(negedge clk) begin
    if (a_rv) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL a_rd_extra: read data %0h with nothing expected", a_rd);
      end else chk("a_rd", a_rd, qa.pop_front());
    end
    if (b_rv) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL b_rd_extra: read data %0h with nothing expected", b_rd);
      end else chk("b_rd", b_rd, qb.pop_front());
    end
  end

  task automatic fill_a(input logic [7:0] d);
    int n = 0;
    logic bad = 0;
    a_fd = d;
    a_fs = 1;
    #1 chk("a_ready_at_start", a_wr, 0);
    cyc();
    a_fs = 0;
    while (a_busy && n < 100) begin
      n++;
      if (a_wr) bad = 1;
      cyc();
    end
    a_wv = 0;
    chk("a_ready_in_fill", bad, 0);
    chk("a_busy_cycles", n, 16);
    chk("a_done_pulse", a_done, 1);
    cyc();
    chk("a_done_low", a_done, 0);
    for (int i = 0; i < 16; i++) ma[i] = d;
  endtask

  task automatic read_all_a();
    for (int i = 0; i < 16; i++) begin
      a_re = 1;
      a_ra = 4'(i);
      qa.push_back(ma[i]);
      cyc();
    end
    a_re = 0;
    cyc();
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_ready", a_wr, 1);
    cyc();
    rst_n = 1;
    chk("ready_after_rst", a_wr, 1);
    fill_a(8'h00);
    a_wv = 1; a_wa = 3; a_wd = 8'hA5;
    chk("ready_write", a_wr, 1);
    cyc();
    a_wv = 0;
    ma[3] = 8'hA5;
    read_all_a();
    fill_a(8'h3C);
    read_all_a();
    a_wv = 1; a_wa = 5; a_wd = 8'hEE;
    fill_a(8'h5A);
    read_all_a();
    fill_a(8'h00);
    a_fd = 8'h11;
    a_fs = 1;
    cyc();
    a_fs = 0;
    repeat (4) cyc();
    a_re = 1; a_ra = 0;
    qa.push_back(8'h11);
    cyc();
    a_re = 0;
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_busy", a_busy, 0);
    chk("abort_rd", a_rd, 0);
    chk("abort_done", a_done, 0);
    cyc();
    rst_n = 1;
    n = 0;
    repeat (4) begin
      cyc();
      if (a_done) n++;
    end
    chk("abort_no_done", n, 0);
    for (int i = 0; i < 5; i++) ma[i] = 8'h11;
    read_all_a();
    a_wv = 1; a_wa = 9; a_wd = 8'h77;
    a_re = 1; a_ra = 9;
`ifdef RAM_WR_BYPASS_EN
    qa.push_back(8'h77);
`else
    qa.push_back(8'h00);
`endif
    cyc();
    a_wv = 0;
    a_re = 0;
    ma[9] = 8'h77;
    a_re = 1;
    qa.push_back(8'h77);
    cyc();
    a_re = 0;
    cyc();
    b_fd = 8'h42;
    b_fs = 1;
    #1 chk("b_ready_at_start", b_wr, 0);
    cyc();
    b_fs = 0;
    n = 0;
    while (b_busy && n < 100) begin
      n++;
      cyc();
    end
    chk("b_busy_cycles", n, 10);
    chk("b_done_pulse", b_done, 1);
    b_wv = 1; b_wa = 12; b_wd = 8'h99;
    chk("b_ready_oob", b_wr, 1);
    cyc();
    b_wv = 0;
    for (int i = 0; i < 10; i++) begin
      b_re = 1;
      b_ra = 4'(i);
      qb.push_back(8'h42);
      cyc();
    end
    b_re = 0;
    repeat (3) cyc();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
